// File: rtl/dma_16b_32b_pkg.sv
// Shared frame-buffer definitions for the 16-bit to 32-bit DMA packer.
package dma_16b_32b_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LINE_CNT_W     = 12;
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = {LINE_CNT_W{1'b1}};

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  function automatic logic [31:0] pack_word(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dma_16b_32b_if.sv
// Video-in / word-out bus of the packer; master is the packer side.
interface dma_16b_32b_if;
  import dma_16b_32b_pkg::*;

  logic                  dma_de_16b_i;
  logic [15:0]           dma_d_16b_i;
  logic                  dma_wr_valid_o;
  logic [31:0]           dma_d_32b_o;
  logic                  dma_wr_ready_i;
  logic                  dma_line_done_o;
  logic [LINE_CNT_W-1:0] dma_line_words_o;
  logic                  dma_ovf_o;

  modport master (
    input  dma_de_16b_i, dma_d_16b_i, dma_wr_ready_i,
    output dma_wr_valid_o, dma_d_32b_o, dma_line_done_o, dma_line_words_o, dma_ovf_o
  );

  modport slave (
    output dma_de_16b_i, dma_d_16b_i, dma_wr_ready_i,
    input  dma_wr_valid_o, dma_d_32b_o, dma_line_done_o, dma_line_words_o, dma_ovf_o
  );

endinterface

// File: rtl/dma_16b_32b_word_fifo.sv
// First-word-fall-through word FIFO; pointers carry one extra wrap bit for full/empty.
module dma_word_fifo
  import dma_16b_32b_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             pop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr_en_s;

  always_comb begin
    empty   = (wr_ptr_r == rd_ptr_r);
    full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop     = rd_ready & ~empty;
    wr_en_s = push & (~full | pop);
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (srst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_16b_32b.sv
// Packs a 16-bit video pixel stream into 32-bit words, pads odd lines, buffers words in a FWFT FIFO.
module dma_16b_32b
  import dma_16b_32b_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           dma_rst_i,
  dma_16b_32b_if.master  bus
);

  logic                  de_r, de_prev_r, armed_r, in_line_r;
  logic [15:0]           d_r, low_r;
  phase_t                phase_r, phase_nxt_s;
  logic                  rise_s, fall_s, pix_s;
  logic                  push_s, pad_s, store_lo_s;
  logic [31:0]           word_s, word_r;
  logic                  push_r, pad_r, line_done_r, ovf_r;
  logic [LINE_CNT_W-1:0] line_words_r;
  logic                  fifo_empty_s, fifo_full_s, fifo_pop_s;

  // armed_r blocks a line start until DE has been seen low after any reset.
  assign rise_s = de_r & ~de_prev_r & armed_r;
  assign fall_s = ~de_r & de_prev_r & in_line_r;
  assign pix_s  = de_r & (rise_s | in_line_r);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_r      <= 1'b0;
      d_r       <= 16'h0000;
      de_prev_r <= 1'b0;
      armed_r   <= 1'b0;
      in_line_r <= 1'b0;
    end else if (dma_rst_i) begin
      de_r      <= 1'b0;
      d_r       <= 16'h0000;
      de_prev_r <= 1'b0;
      armed_r   <= 1'b0;
      in_line_r <= 1'b0;
    end else begin
      de_r      <= bus.dma_de_16b_i;
      d_r       <= bus.dma_d_16b_i;
      de_prev_r <= de_r;
      armed_r   <= armed_r | ~bus.dma_de_16b_i;
      if (rise_s) begin
        in_line_r <= 1'b1;
      end else if (fall_s) begin
        in_line_r <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= PH_LOW;
    end else if (dma_rst_i) begin
      phase_r <= PH_LOW;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  always_comb begin
    phase_nxt_s = phase_r;
    if (rise_s) begin
      phase_nxt_s = PH_HIGH;
    end else if (pix_s) begin
      case (phase_r)
        PH_LOW:  phase_nxt_s = PH_HIGH;
        PH_HIGH: phase_nxt_s = PH_LOW;
        default: phase_nxt_s = PH_LOW;
      endcase
    end else if (fall_s) begin
      phase_nxt_s = PH_LOW;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  always_comb begin
    push_s     = 1'b0;
    pad_s      = 1'b0;
    store_lo_s = 1'b0;
    word_s     = pack_word(d_r, low_r);
    if (rise_s) begin
      store_lo_s = 1'b1;
    end else if (pix_s) begin
      case (phase_r)
        PH_LOW:  store_lo_s = 1'b1;
        PH_HIGH: push_s     = 1'b1;
        default: store_lo_s = 1'b0;
      endcase
    end else if (fall_s && (phase_r == PH_HIGH)) begin
      push_s = 1'b1;
      pad_s  = 1'b1;
      word_s = pack_word(16'h0000, low_r);
    end else begin
      push_s = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      low_r  <= 16'h0000;
      push_r <= 1'b0;
      pad_r  <= 1'b0;
      word_r <= 32'h0000_0000;
    end else if (dma_rst_i) begin
      low_r  <= 16'h0000;
      push_r <= 1'b0;
      pad_r  <= 1'b0;
      word_r <= 32'h0000_0000;
    end else begin
      if (store_lo_s) low_r <= d_r;
      push_r <= push_s;
      pad_r  <= pad_s;
      word_r <= word_s;
    end
  end

  // An even line ends with the push already in flight when the fall is seen; an odd one with its pad.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_words_r <= {LINE_CNT_W{1'b0}};
      line_done_r  <= 1'b0;
      ovf_r        <= 1'b0;
    end else if (dma_rst_i) begin
      line_words_r <= {LINE_CNT_W{1'b0}};
      line_done_r  <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      if (rise_s) begin
        line_words_r <= {LINE_CNT_W{1'b0}};
      end else if (push_r && (line_words_r != LINE_CNT_MAX)) begin
        line_words_r <= line_words_r + {{(LINE_CNT_W-1){1'b0}}, 1'b1};
      end
      line_done_r <= (fall_s & (phase_r == PH_LOW)) | (push_r & pad_r);
      ovf_r       <= ovf_r | (push_r & fifo_full_s & ~fifo_pop_s);
    end
  end

  dma_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .srst     (dma_rst_i),
    .push     (push_r),
    .din      (word_r),
    .rd_ready (bus.dma_wr_ready_i),
    .dout     (bus.dma_d_32b_o),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s),
    .pop      (fifo_pop_s)
  );

  assign bus.dma_wr_valid_o   = ~fifo_empty_s;
  assign bus.dma_line_done_o  = line_done_r;
  assign bus.dma_line_words_o = line_words_r;
  assign bus.dma_ovf_o        = ovf_r;

endmodule

// File: doc/dma_16b_32b.md
DMA_16B_32B -- requirements
Module: dma_16b_32b

Interface
REQ-001 SHALL provide sys_clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide dma_rst_i  input  1  synchronous frame restart; clears datapath, FIFO, counters, flags.
REQ-004 SHALL provide dma_de_16b_i  input  1  video data enable, one 16-bit pixel per high cycle.
REQ-005 SHALL provide dma_d_16b_i  input  16  pixel data, valid when dma_de_16b_i=1.
REQ-006 SHALL provide dma_wr_valid_o  output  1  packed 32-bit word available.
REQ-007 SHALL provide dma_d_32b_o  output  32  packed word, valid when dma_wr_valid_o=1.
REQ-008 SHALL provide dma_wr_ready_i  input  1  write side accepts the word; transfer = valid & ready.
REQ-009 SHALL provide dma_line_done_o  output  1  one-cycle pulse after the last word of a line enters the FIFO.
REQ-010 SHALL provide dma_line_words_o  output  12  words pushed in the current/most recent line.
REQ-011 SHALL provide dma_ovf_o  output  1  sticky overflow flag.
REQ-012 SHALL use parameter FIFO_DEPTH, default 4, power of two, word FIFO depth.

Function
REQ-013 SHALL register dma_de_16b_i and dma_d_16b_i in one input stage before packing.
REQ-014 SHALL detect line start as registered DE rising (DE=1, previous DE=0) and reset the half-word phase to LOW.
REQ-015 SHALL pack with a two-state phase FSM: LOW stores the pixel in bits [15:0] and moves to HIGH; HIGH places the pixel in [31:16], pushes the word, returns to LOW.
REQ-016 SHALL, on registered DE falling while phase=HIGH-pending (odd pixel count), push one word with [31:16]=16'h0000 and return to LOW.
REQ-017 SHALL produce the first dma_wr_valid_o 3 cycles after the second pixel of a line is presented, with the FIFO empty.
REQ-018 SHALL implement a first-word-fall-through FIFO of FIFO_DEPTH words; dma_wr_valid_o = FIFO not empty; dma_d_32b_o = FIFO head.
REQ-019 SHALL pop the FIFO only on dma_wr_valid_o & dma_wr_ready_i.
REQ-020 SHALL accept simultaneous push and pop when full, count unchanged, no overflow.
REQ-021 SHALL, on push into a full FIFO without simultaneous pop, drop the incoming word and set dma_ovf_o until dma_rst_i or rst_n.
REQ-022 SHALL never pop an empty FIFO; ready while empty has no effect.
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, using an extra pointer bit or count for full/empty.
REQ-024 SHALL clear dma_line_words_o on line start, increment per push attempt (dropped words included), and saturate at 4095.
REQ-025 SHALL assert dma_line_done_o exactly one cycle, on the cycle after the line's final push attempt (even or padded word).
REQ-026 SHALL give dma_rst_i priority over all other events in the same cycle; a pending half-word is discarded, no padded word is emitted.
REQ-027 SHALL treat a one-pixel line as odd: one word {16'h0000, pixel}.

Reset
REQ-028 SHALL on rst_n=0 drive dma_wr_valid_o=0, dma_d_32b_o=0, dma_line_done_o=0, dma_line_words_o=0, dma_ovf_o=0, phase=LOW, FIFO empty, input stage cleared.
REQ-029 SHALL release reset cleanly mid-line: DE high at release is not a line start until DE is seen low, then high.
REQ-030 SHALL make dma_rst_i produce the same output values as rst_n, one cycle later and synchronously.

Structure
REQ-031 SHALL place FIFO_DEPTH default, the 12-bit line-count width, and the phase-state encoding (LOW=0, HIGH=1) in the shared frame-buffer package.
REQ-032 SHALL implement the word FIFO as sub-module dma_word_fifo (FWFT, parameterized depth/width); packing FSM and counters stay in dma_16b_32b.

Verification
REQ-033 SHALL test an even line: 4 pixels 0x1111,0x2222,0x3333,0x4444, ready=1 -> words 0x22221111, 0x44443333; line_words=2; one line_done pulse; first valid 3 cycles after 0x2222.
REQ-034 SHALL test an odd line: 3 pixels 0xAAAA,0xBBBB,0xCCCC -> 0xBBBBAAAA, 0x0000CCCC; line_words=2.
REQ-035 SHALL test backpressure: ready=0, 10-pixel line -> 4 words held, 5th dropped, ovf=1 sticky; then ready=1 -> exactly 4 words drain in order; line_words=5.
REQ-036 SHALL test full with simultaneous push/pop: FIFO full, ready=1 on push cycle -> no overflow, count stays 4.
REQ-037 SHALL test dma_rst_i after 1 pixel of a line -> no word emitted, valid=0, ovf=0, line_words=0 next cycle.
REQ-038 SHALL test rst_n asserted with DE high mid-line -> all outputs 0; after release, output stays idle until the next DE low-to-high.
